// File: rtl/binary_bbox_tracker.sv
// Per-frame bounding box and set-pixel counter for a raster-ordered binary mask stream.
// Publishes one latched result set, plus a one-cycle done pulse, at the last pixel of every frame.
module binary_bbox_tracker #(
  parameter int IMAGE_W    = 640,
  parameter int IMAGE_H    = 480,
  parameter int MIN_PIXELS = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        i_pixel,
  input  logic        i_pixel_valid,
  input  logic        i_sof,
  output logic        o_frame_done,
  output logic        o_detected,
  output logic [10:0] o_x_min,
  output logic [10:0] o_x_max,
  output logic [10:0] o_y_min,
  output logic [10:0] o_y_max,
  output logic [19:0] o_pixel_count
);

  localparam logic [10:0] X_LAST  = 11'(IMAGE_W - 1);
  localparam logic [10:0] Y_LAST  = 11'(IMAGE_H - 1);
  localparam logic [19:0] CNT_MAX = '1;
  localparam logic [31:0] MIN_CMP = 32'(MIN_PIXELS);

  typedef enum logic {IDLE, ACCUM} state_t;

  state_t      state, state_next;
  logic [10:0] x_cnt, y_cnt;
  logic [10:0] run_xmin, run_xmax, run_ymin, run_ymax;
  logic [19:0] run_cnt;
  logic        run_any;

  logic [10:0] px, py;
  logic        base_any;
  logic [19:0] base_cnt;
  logic [10:0] xmin_next, xmax_next, ymin_next, ymax_next;
  logic [19:0] cnt_next;
  logic        any_next;
  logic        det_next;
  logic        eof;

  always_comb begin
    state_next = state;
    if (i_pixel_valid) state_next = ACCUM;

    // A start-of-frame pixel is position (0,0) of an empty frame, whatever came before.
    px       = i_sof ? 11'd0 : x_cnt;
    py       = i_sof ? 11'd0 : y_cnt;
    base_any = (state == ACCUM) && !i_sof && run_any;
    base_cnt = base_any ? run_cnt : 20'd0;

    xmin_next = run_xmin;
    xmax_next = run_xmax;
    ymin_next = run_ymin;
    ymax_next = run_ymax;
    cnt_next  = base_cnt;
    any_next  = base_any;
    if (i_pixel) begin
      xmin_next = (!base_any || px < run_xmin) ? px : run_xmin;
      xmax_next = (!base_any || px > run_xmax) ? px : run_xmax;
      ymin_next = (!base_any || py < run_ymin) ? py : run_ymin;
      ymax_next = (!base_any || py > run_ymax) ? py : run_ymax;
      any_next  = 1'b1;
      if (base_cnt != CNT_MAX) cnt_next = base_cnt + 20'd1;
    end

    det_next = ({12'd0, cnt_next} >= MIN_CMP);
    eof      = i_pixel_valid && (px == X_LAST) && (py == Y_LAST);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= IDLE;
      x_cnt         <= '0;
      y_cnt         <= '0;
      run_xmin      <= '0;
      run_xmax      <= '0;
      run_ymin      <= '0;
      run_ymax      <= '0;
      run_cnt       <= '0;
      run_any       <= 1'b0;
      o_frame_done  <= 1'b0;
      o_detected    <= 1'b0;
      o_x_min       <= '0;
      o_x_max       <= '0;
      o_y_min       <= '0;
      o_y_max       <= '0;
      o_pixel_count <= '0;
    end else begin
      state        <= state_next;
      o_frame_done <= eof;
      if (i_pixel_valid) begin
        if (eof) begin
          x_cnt         <= '0;
          y_cnt         <= '0;
          run_xmin      <= '0;
          run_xmax      <= '0;
          run_ymin      <= '0;
          run_ymax      <= '0;
          run_cnt       <= '0;
          run_any       <= 1'b0;
          o_pixel_count <= cnt_next;
          o_detected    <= det_next;
          o_x_min       <= det_next ? xmin_next : 11'd0;
          o_x_max       <= det_next ? xmax_next : 11'd0;
          o_y_min       <= det_next ? ymin_next : 11'd0;
          o_y_max       <= det_next ? ymax_next : 11'd0;
        end else begin
          if (px == X_LAST) begin
            x_cnt <= '0;
            y_cnt <= py + 11'd1;
          end else begin
            x_cnt <= px + 11'd1;
            y_cnt <= py;
          end
          run_xmin <= xmin_next;
          run_xmax <= xmax_next;
          run_ymin <= ymin_next;
          run_ymax <= ymax_next;
          run_cnt  <= cnt_next;
          run_any  <= any_next;
        end
      end
    end
  end

endmodule

// File: tb/tb_binary_bbox_tracker.sv
// Randomized scoreboard bench: two trackers (MIN_PIXELS 1 and 3) share one 9x6 stream and
// are checked against a frame-buffer model that recomputes each box from the stored pixels.
module tb_binary_bbox_tracker;
  localparam int W = 9;
  localparam int H = 6;
  localparam int N = W * H;

  typedef struct packed {
    logic        det;
    logic [10:0] xmin;
    logic [10:0] xmax;
    logic [10:0] ymin;
    logic [10:0] ymax;
    logic [19:0] cnt;
  } res_t;

  typedef struct {
    res_t r;
    int   neg;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic pixel = 1'b0;
  logic pixel_valid = 1'b0;
  logic sof = 1'b0;

  logic        done [2];
  logic        det [2];
  logic [10:0] xmin [2], xmax [2], ymin [2], ymax [2];
  logic [19:0] cnt [2];
  res_t        got [2];

  int   checks = 0;
  int   failures = 0;
  int   neg_cnt = 0;
  exp_t q0[$];
  exp_t q1[$];
  res_t held [2];
  bit   frame_mem [N];
  int   pix_idx = 0;
  int   min_of [2] = '{1, 3};

  always #5 clk = ~clk;

  binary_bbox_tracker #(.IMAGE_W(W), .IMAGE_H(H), .MIN_PIXELS(1)) dut (
    .clk(clk), .rst_n(rst_n), .i_pixel(pixel), .i_pixel_valid(pixel_valid), .i_sof(sof),
    .o_frame_done(done[0]), .o_detected(det[0]), .o_x_min(xmin[0]), .o_x_max(xmax[0]),
    .o_y_min(ymin[0]), .o_y_max(ymax[0]), .o_pixel_count(cnt[0]));

  binary_bbox_tracker #(.IMAGE_W(W), .IMAGE_H(H), .MIN_PIXELS(3)) dut_min3 (
    .clk(clk), .rst_n(rst_n), .i_pixel(pixel), .i_pixel_valid(pixel_valid), .i_sof(sof),
    .o_frame_done(done[1]), .o_detected(det[1]), .o_x_min(xmin[1]), .o_x_max(xmax[1]),
    .o_y_min(ymin[1]), .o_y_max(ymax[1]), .o_pixel_count(cnt[1]));

  assign got[0] = {det[0], xmin[0], xmax[0], ymin[0], ymax[0], cnt[0]};
  assign got[1] = {det[1], xmin[1], xmax[1], ymin[1], ymax[1], cnt[1]};

  function automatic string fmt(input res_t r);
    return $sformatf("det=%0d x=%0d..%0d y=%0d..%0d cnt=%0d",
                     r.det, r.xmin, r.xmax, r.ymin, r.ymax, r.cnt);
  endfunction

  // Reference: scan the stored frame, derive coordinates from pixel index.
  function automatic res_t frame_result(input int minp);
    res_t r;
    int c = 0, x0 = W, x1 = -1, y0 = H, y1 = -1;
    for (int i = 0; i < N; i++) begin
      if (frame_mem[i]) begin
        c++;
        if (i % W < x0) x0 = i % W;
        if (i % W > x1) x1 = i % W;
        if (i / W < y0) y0 = i / W;
        if (i / W > y1) y1 = i / W;
      end
    end
    r = '0;
    r.cnt = 20'(c);
    r.det = (c >= minp);
    if (r.det) begin
      r.xmin = 11'(x0); r.xmax = 11'(x1); r.ymin = 11'(y0); r.ymax = 11'(y1);
    end
    return r;
  endfunction

  task automatic model_pixel(input bit p, input bit s);
    exp_t e;
    if (s) begin
      pix_idx = 0;
      for (int i = 0; i < N; i++) frame_mem[i] = 1'b0;
    end
    frame_mem[pix_idx] = p;
    pix_idx++;
    if (pix_idx == N) begin
      e.neg = neg_cnt + 2;
      e.r = frame_result(min_of[0]); q0.push_back(e);
      e.r = frame_result(min_of[1]); q1.push_back(e);
      $display("frame end expected: min1 %s | min3 %s", fmt(q0[$].r), fmt(q1[$].r));
      pix_idx = 0;
    end
  endtask

  // Entered and left at posedge+1; noise on invalid cycles must be ignored.
  task automatic send(input bit p, input bit s, input int max_gap);
    int gaps = (max_gap > 0) ? $urandom_range(0, max_gap) : 0;
    repeat (gaps) begin
      pixel_valid = 1'b0;
      pixel = 1'($urandom);
      sof = 1'($urandom);
      @(posedge clk); #1;
    end
    pixel_valid = 1'b1;
    pixel = p;
    sof = s;
    model_pixel(p, s);
    @(posedge clk); #1;
    pixel_valid = 1'b0;
    pixel = 1'b0;
    sof = 1'b0;
  endtask

  task automatic send_frame(input bit [N-1:0] bits, input int max_gap);
    for (int i = 0; i < N; i++) send(bits[i], 1'b0, max_gap);
  endtask

  task automatic check_zero(input string name);
    for (int k = 0; k < 2; k++) begin
      checks++;
      if (got[k] !== '0 || done[k] !== 1'b0) begin
        failures++;
        $display("FAIL %s dut%0d: got %s done=%0d, want all zero", name, k, fmt(got[k]), done[k]);
      end
    end
  endtask

  task automatic do_reset();
    held[0] = '0;
    held[1] = '0;
    q0.delete();
    q1.delete();
    pix_idx = 0;
    rst_n = 1'b0;
    #1;
    check_zero("reset_immediate");
    @(posedge clk); #1;
    rst_n = 1'b1;
  endtask

  task automatic mon_one(input int k);
    exp_t e;
    bit have;
    have = (k == 0) ? (q0.size() > 0) : (q1.size() > 0);
    if (have) e = (k == 0) ? q0[0] : q1[0];
    if (done[k] === 1'b1) begin
      checks++;
      if (!have) begin
        failures++;
        $display("FAIL unexpected_done dut%0d at neg %0d: got %s, want no pulse", k, neg_cnt, fmt(got[k]));
      end else begin
        if (k == 0) void'(q0.pop_front()); else void'(q1.pop_front());
        if (got[k] !== e.r || neg_cnt != e.neg) begin
          failures++;
          $display("FAIL frame_result dut%0d: got %s at neg %0d, want %s at neg %0d",
                   k, fmt(got[k]), neg_cnt, fmt(e.r), e.neg);
        end else begin
          $display("frame_done dut%0d ok: %s", k, fmt(got[k]));
        end
        held[k] = e.r;
      end
    end else begin
      if (have && e.neg <= neg_cnt) begin
        checks++;
        failures++;
        $display("FAIL missing_done dut%0d: no pulse at neg %0d, want %s", k, neg_cnt, fmt(e.r));
        if (k == 0) void'(q0.pop_front()); else void'(q1.pop_front());
        held[k] = e.r;
      end
      checks++;
      if (got[k] !== held[k]) begin
        failures++;
        $display("FAIL outputs_hold dut%0d at neg %0d: got %s, want %s", k, neg_cnt, fmt(got[k]), fmt(held[k]));
      end
    end
  endtask

  initial begin
    forever begin
      @(negedge clk);
      neg_cnt++;
      mon_one(0);
      mon_one(1);
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: bench did not finish, want completion");
    $fatal(1, "watchdog");
  end

  initial begin
    bit [N-1:0] bits;
    held[0] = '0;
    held[1] = '0;
    #1;
    check_zero("reset_state");
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;

    // 1: all-zero frame
    send_frame('0, 0);

    // 2: ones at (2,1) and (6,4)
    bits = '0;
    bits[1*W+2] = 1'b1;
    bits[4*W+6] = 1'b1;
    send_frame(bits, 0);

    // 3: same frame with gaps and noise on invalid cycles
    send_frame(bits, 3);

    // 4: sof at the 20th valid pixel, then a frame whose only one is at (8,5)
    for (int i = 0; i < 19; i++) send((i == 0) ? 1'b1 : 1'($urandom), 1'b0, 1);
    send(1'b0, 1'b1, 1);
    for (int i = 1; i < N; i++) send((i == N - 1) ? 1'b1 : 1'b0, 1'b0, 1);

    // Random frames, occasional mid-frame sof
    for (int f = 0; f < 5; f++) begin
      int dens = $urandom_range(0, 40);
      for (int i = 0; i < N; i++)
        send(($urandom_range(0, 99) < dens), ($urandom_range(0, 79) == 0), 2);
    end
    while (pix_idx != 0) send(1'($urandom), 1'b0, 1);

    // 5: two ones (below MIN_PIXELS=3 for the second tracker), then reset mid-frame
    bits = '0;
    bits[0] = 1'b1;
    bits[2*W+3] = 1'b1;
    send_frame(bits, 1);
    for (int i = 0; i < 12; i++) send(1'b1, 1'b0, 1);
    do_reset();

    // Recovery after reset
    for (int i = 0; i < N; i++) send(($urandom_range(0, 99) < 30), 1'b0, 2);

    repeat (5) @(posedge clk);
    #1;
    checks++;
    if (q0.size() != 0 || q1.size() != 0) begin
      failures++;
      $display("FAIL pending_results: got %0d/%0d undelivered, want 0/0", q0.size(), q1.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
